// File: rtl/alu_seq_if.sv
// Operand/result bundle between the operand register file (master) and alu_seq (slave).
interface alu_seq_if #(
    parameter int W = 4
);
    logic         start;
    logic [1:0]   cls;
    logic [1:0]   Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         use_c;
    logic [W-1:0] R;
    logic         z;
    logic         c;
    logic         s;
    logic         v;
    logic         busy;
    logic         done;

    modport master (
        output start, cls, Op, A, B, cin, use_c,
        input  R, z, c, s, v, busy, done
    );

    modport slave (
        input  start, cls, Op, A, B, cin, use_c,
        output R, z, c, s, v, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Registered W-bit ALU: 1-cycle arith/logic/compare, n-cycle bit-serial shift/rotate.
// Stored carry can be chained into the next op as carry-in for wide arithmetic.
//
//   state | meaning
//   IDLE  | accepts start; arith/logic/compare and n=0 shifts complete on the accept edge
//   SHIFT | one bit per cycle on the latched operand; completes when the count reaches 0
module alu_seq #(
    parameter int W = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_work;
    logic [SW-1:0] r_cnt;
    logic [1:0]    r_op;
    logic [W-1:0]  r_R;
    logic          r_z;
    logic          r_c;
    logic          r_s;
    logic          r_v;
    logic          r_busy;
    logic          r_done;

    logic [W-1:0]  w_x;
    logic [W-1:0]  w_y;
    logic          w_cin;
    logic [W:0]    w_sum;
    logic          w_ovf;
    logic [W-1:0]  w_logic;
    logic [W-1:0]  w_step;
    logic          w_step_out;
    logic [SW-1:0] w_n;

    assign w_n = bus.B[SW-1:0];

    // Compare reuses the adder as A + ~B + 1 with the carry-in forced.
    always_comb begin
        w_x   = bus.A;
        w_y   = '0;
        w_cin = bus.use_c ? r_c : bus.cin;
        if (bus.cls == 2'b11) begin
            w_y   = ~bus.B;
            w_cin = 1'b1;
        end else begin
            case (bus.Op)
                2'b00:   w_y = '0;
                2'b01: begin
                    w_x = ~bus.A;
                    w_y = W'(1);
                end
                2'b10:   w_y = bus.B;
                default: w_y = W'(1);
            endcase
        end
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, w_cin};
        w_ovf = (w_x[W-1] == w_y[W-1]) && (w_sum[W-1] != w_x[W-1]);
    end

    always_comb begin
        case (bus.Op)
            2'b00:   w_logic = bus.A & bus.B;
            2'b01:   w_logic = bus.A | bus.B;
            2'b10:   w_logic = bus.A ^ bus.B;
            default: w_logic = ~bus.A;
        endcase
    end

    always_comb begin
        w_step     = r_work;
        w_step_out = 1'b0;
        case (r_op)
            2'b00: begin
                w_step     = {r_work[W-2:0], 1'b0};
                w_step_out = r_work[W-1];
            end
            2'b01: begin
                w_step     = {1'b0, r_work[W-1:1]};
                w_step_out = r_work[0];
            end
            2'b10: begin
                w_step     = {r_work[W-1], r_work[W-1:1]};
                w_step_out = r_work[0];
            end
            default: begin
                w_step     = {r_work[W-2:0], r_work[W-1]};
                w_step_out = r_work[W-1];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_R     <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_s     <= 1'b0;
            r_v     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.cls)
                            2'b00: begin
                                r_R    <= w_sum[W-1:0];
                                r_z    <= (w_sum[W-1:0] == '0);
                                r_c    <= w_sum[W];
                                r_s    <= w_sum[W-1];
                                r_v    <= w_ovf;
                                r_done <= 1'b1;
                            end
                            2'b01: begin
                                r_R    <= w_logic;
                                r_z    <= (w_logic == '0);
                                r_c    <= 1'b0;
                                r_s    <= w_logic[W-1];
                                r_v    <= 1'b0;
                                r_done <= 1'b1;
                            end
                            2'b11: begin
                                r_z    <= (w_sum[W-1:0] == '0);
                                r_c    <= w_sum[W];
                                r_s    <= w_sum[W-1];
                                r_v    <= w_ovf;
                                r_done <= 1'b1;
                            end
                            default: begin
                                if (w_n == '0) begin
                                    r_R    <= bus.A;
                                    r_z    <= (bus.A == '0);
                                    r_c    <= 1'b0;
                                    r_s    <= bus.A[W-1];
                                    r_v    <= 1'b0;
                                    r_done <= 1'b1;
                                end else begin
                                    r_work  <= bus.A;
                                    r_cnt   <= w_n;
                                    r_op    <= bus.Op;
                                    r_busy  <= 1'b1;
                                    r_state <= SHIFT;
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - SW'(1);
                    if (r_cnt == SW'(1)) begin
                        r_R     <= w_step;
                        r_z     <= (w_step == '0);
                        r_c     <= w_step_out;
                        r_s     <= w_step[W-1];
                        r_v     <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.R    = r_R;
    assign bus.z    = r_z;
    assign bus.c    = r_c;
    assign bus.s    = r_s;
    assign bus.v    = r_v;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector and exhaustive model bench for alu_seq at W=4.
module tb_alu_seq;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cls;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       use_c;
        int         lat;
        logic [7:0] exp;   // {R, z, c, s, v}
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] flags_now();
        return {bus.R, bus.z, bus.c, bus.s, bus.v};
    endfunction

    task automatic launch(input logic [1:0] cl, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic ci, input logic uc, output int lat);
        @(negedge clk);
        bus.cls = cl; bus.Op = op; bus.A = a; bus.B = b; bus.cin = ci; bus.use_c = uc;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Independent integer model; returns {R, z, c, s, v}.
    function automatic logic [7:0] model(input int cl, input int op, input int a, input int b,
                                         input int ci, input int prev_r);
        int x, y, sum, r, d, c, v, n, sa;
        x = 0; y = 0; sum = 0; r = 0; d = 0; c = 0; v = 0;
        n = b & 3;
        if (cl == 0) begin
            case (op)
                0: begin x = a; y = 0; end
                1: begin x = (~a) & 15; y = 1; end
                2: begin x = a; y = b; end
                default: begin x = a; y = 1; end
            endcase
            sum = x + y + ci;
            r = sum & 15; d = r; c = (sum >> 4) & 1;
            v = (((x >> 3) == (y >> 3)) && ((r >> 3) != (x >> 3))) ? 1 : 0;
        end else if (cl == 1) begin
            case (op)
                0: r = a & b;
                1: r = a | b;
                2: r = a ^ b;
                default: r = (~a) & 15;
            endcase
            d = r;
        end else if (cl == 3) begin
            x = a; y = (~b) & 15;
            sum = x + y + 1;
            d = sum & 15; c = (sum >> 4) & 1; r = prev_r;
            v = (((x >> 3) == (y >> 3)) && ((d >> 3) != (x >> 3))) ? 1 : 0;
        end else begin
            sa = (a >= 8) ? a - 16 : a;
            if (n == 0) begin
                r = a; c = 0;
            end else begin
                case (op)
                    0: begin r = (a << n) & 15; c = (a >> (4 - n)) & 1; end
                    1: begin r = a >> n; c = (a >> (n - 1)) & 1; end
                    2: begin r = (sa >>> n) & 15; c = (sa >>> (n - 1)) & 1; end
                    default: begin r = ((a << n) | (a >> (4 - n))) & 15; c = r & 1; end
                endcase
            end
            d = r;
        end
        return 8'((r << 4) | ((d == 0 ? 1 : 0) << 3) | (c << 2) | (((d >> 3) & 1) << 1) | v);
    endfunction

    vec_t vecs[20];

    initial begin
        int lat;
        int nd;
        logic [7:0] e;
        int mr, mc, ci;

        //        cls    op     a      b      cin   uc    lat  {R,z,c,s,v}
        vecs[0]  = '{2'b00, 2'b10, 4'h7, 4'h1, 1'b0, 1'b0, 0, 8'b1000_0011};
        vecs[1]  = '{2'b00, 2'b10, 4'hF, 4'h1, 1'b0, 1'b0, 0, 8'b0000_1100};
        vecs[2]  = '{2'b00, 2'b10, 4'h0, 4'h0, 1'b0, 1'b1, 0, 8'b0001_0000};
        vecs[3]  = '{2'b10, 2'b00, 4'h6, 4'h2, 1'b0, 1'b0, 2, 8'b1000_0110};
        vecs[4]  = '{2'b11, 2'b00, 4'h3, 4'h5, 1'b0, 1'b0, 0, 8'b1000_0010};
        vecs[5]  = '{2'b00, 2'b00, 4'h9, 4'h0, 1'b1, 1'b0, 0, 8'b1010_0010};
        vecs[6]  = '{2'b00, 2'b01, 4'h3, 4'h0, 1'b0, 1'b0, 0, 8'b1101_0010};
        vecs[7]  = '{2'b00, 2'b11, 4'h7, 4'h0, 1'b1, 1'b0, 0, 8'b1001_0011};
        vecs[8]  = '{2'b00, 2'b11, 4'hF, 4'h0, 1'b0, 1'b0, 0, 8'b0000_1100};
        vecs[9]  = '{2'b01, 2'b00, 4'hC, 4'hA, 1'b0, 1'b0, 0, 8'b1000_0010};
        vecs[10] = '{2'b01, 2'b01, 4'h5, 4'hA, 1'b1, 1'b0, 0, 8'b1111_0010};
        vecs[11] = '{2'b01, 2'b10, 4'hA, 4'hA, 1'b0, 1'b0, 0, 8'b0000_1000};
        vecs[12] = '{2'b01, 2'b11, 4'hF, 4'h0, 1'b0, 1'b0, 0, 8'b0000_1000};
        vecs[13] = '{2'b11, 2'b00, 4'h5, 4'h5, 1'b0, 1'b0, 0, 8'b0000_1100};
        vecs[14] = '{2'b11, 2'b00, 4'h8, 4'h1, 1'b0, 1'b0, 0, 8'b0000_0101};
        vecs[15] = '{2'b10, 2'b01, 4'h9, 4'h1, 1'b0, 1'b0, 1, 8'b0100_0100};
        vecs[16] = '{2'b10, 2'b10, 4'h8, 4'h3, 1'b0, 1'b0, 3, 8'b1111_0010};
        vecs[17] = '{2'b10, 2'b11, 4'h9, 4'h1, 1'b0, 1'b0, 1, 8'b0011_0100};
        vecs[18] = '{2'b10, 2'b00, 4'h5, 4'h4, 1'b0, 1'b0, 0, 8'b0101_0000};
        vecs[19] = '{2'b10, 2'b11, 4'h6, 4'h3, 1'b0, 1'b0, 3, 8'b0011_0100};

        bus.start = 1'b0; bus.cls = 2'b00; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
        bus.cin = 1'b0; bus.use_c = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {flags_now(), bus.busy, bus.done}, 10'h000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            launch(vecs[i].cls, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].use_c, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_result", i), flags_now(), vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), bus.done, 1'b0);
        end

        // Shift with start pulses while busy: exactly one done, arith op not executed.
        @(negedge clk);
        bus.cls = 2'b10; bus.Op = 2'b00; bus.A = 4'h6; bus.B = 4'h2; bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_accept", {bus.busy, bus.done}, 2'b10);
        @(negedge clk);
        bus.cls = 2'b00; bus.Op = 2'b10; bus.A = 4'h1; bus.B = 4'h1;
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        check("busy_start_ignored_dones", nd, 1);
        check("busy_start_ignored_result", flags_now(), 8'b1000_0110);

        // Reset on the second busy cycle of a SAR aborts without done.
        @(negedge clk);
        bus.cls = 2'b10; bus.Op = 2'b10; bus.A = 4'h8; bus.B = 4'h3; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("sar_busy_before_abort", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {flags_now(), bus.busy, bus.done}, 10'h000);
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        check("abort_no_done", nd, 0);
        @(negedge clk);
        reset_n = 1'b1;
        launch(2'b10, 2'b11, 4'h9, 4'h1, 1'b0, 1'b0, lat);
        check("rol_after_abort_latency", lat, 1);
        check("rol_after_abort_result", flags_now(), 8'b0011_0100);

        // Exhaustive single-cycle classes, start held high back-to-back.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mr = 0; mc = 0;
        for (int cl = 0; cl < 4; cl++) begin
            if (cl == 2) continue;
            for (int op = 0; op < 4; op++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        for (int k = 0; k < 4; k++) begin
                            @(negedge clk);
                            bus.cls = 2'(cl); bus.Op = 2'(op); bus.A = 4'(a); bus.B = 4'(b);
                            bus.cin = k[0]; bus.use_c = k[1];
                            bus.start = 1'b1;
                            ci = k[1] ? mc : (k & 1);
                            e = model(cl, op, a, b, ci, mr);
                            @(posedge clk);
                            #1;
                            check($sformatf("exh_c%0d_o%0d_a%0h_b%0h_k%0d", cl, op, a, b, k),
                                  {bus.done, flags_now()}, {1'b1, e});
                            mr = int'(e[7:4]);
                            mc = int'(e[2]);
                        end
        end
        @(negedge clk);
        bus.start = 1'b0;

        // Exhaustive shifts for n = 0..3, upper B bits varied to show they are ignored.
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 16; a++)
                for (int n = 0; n < 4; n++) begin
                    e = model(2, op, a, n, 0, 0);
                    launch(2'b10, 2'(op), 4'(a), {a[1:0], n[1:0]}, 1'b0, 1'b0, lat);
                    check($sformatf("shift_o%0d_a%0h_n%0d_latency", op, a, n), lat, n);
                    check($sformatf("shift_o%0d_a%0h_n%0d_result", op, a, n), flags_now(), e);
                end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
